booth_mac_accumulator: RTL and testbench

Downstream accumulation stage for the 16-bit Booth multiplier. It consumes the 32-bit signed products the multiplier emits and sums a programmable number of them into a wide accumulator. It returns each finished dot-product over a valid/ready handshake. It also reports a sticky per-job overflow flag so filter and dot-product engines can chain jobs without software polling.

---
 rtl/booth_mac_accumulator.sv | 129 ++++++++++++
 tb/tb_booth_mac_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator
// Sums a programmable number of signed Booth-multiplier products into a wide
// accumulator and returns the dot-product over a valid/ready handshake.
// A sticky overflow flag reports any ACC_W signed overflow within a job.
// Optional build macro: BOOTH_MAC_SATURATE_EN -- when defined the accumulator
// clamps to the signed max/min on overflow; otherwise it wraps modulo 2^ACC_W.
module booth_mac_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_out,
  input  logic              acc_ready,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

`ifdef BOOTH_MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               acc_valid_q, acc_valid_d;
  logic               busy_q, busy_d;

  logic [ACC_W:0]     sum_ext;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_res;

  // One-bit-wider signed sum; the two top bits disagree exactly on overflow.
  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q}
            + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef BOOTH_MAC_SATURATE_EN
    // The extra MSB holds the true sign, so it picks the clamp direction.
    if (sum_ovf) begin
      sum_res = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_res = sum_ext[ACC_W-1:0];
    end
`else
    sum_res = sum_ext[ACC_W-1:0];
`endif
  end

  // Next-state and datapath update for the IDLE/ACCUM/HOLD job sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = sum_res;
          rem_d = rem_q - CNT_W'(1);
          if (sum_ovf) begin
            ovf_d = 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    acc_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      acc_valid_q <= acc_valid_d;
      busy_q      <= busy_d;
    end
  end

  // prod_ready depends only on the current state, never on prod_valid.
  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = acc_valid_q;
  assign acc_out    = acc_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Scoreboard bench for booth_mac_accumulator, built with ACC_W=34 so the
// overflow vectors are reachable with 32-bit products.
module tb_booth_mac_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 34;
  localparam int CNT_W  = 8;
  localparam int LIMIT  = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_ready;
  logic              busy;
  logic              overflow;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [ACC_W-1:0] NEG3 = -34'sd3;
  localparam logic [ACC_W-1:0] NEG2 = -34'sd2;
`ifdef BOOTH_MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] OVF_EXP = 34'h1_FFFF_FFFF;
`else
  localparam logic [ACC_W-1:0] OVF_EXP = -34'sd6442450949;
`endif

  booth_mac_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .prod_valid(prod_valid),
    .prod      (prod),
    .prod_ready(prod_ready),
    .acc_valid (acc_valid),
    .acc_out   (acc_out),
    .acc_ready (acc_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_acc", 64'(acc_out), 64'(e.acc));
        chk("result_ovf", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [PROD_W-1:0] p);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod       = p;
    while (!prod_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL prod_ready_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic take_result();
    int n;
    n = 0;
    acc_ready = 1'b1;
    while (!acc_valid && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL acc_valid_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    acc_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_valid", 64'(acc_valid), 64'd0);
    chk("rst_prod_ready", 64'(prod_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_acc_out", 64'(acc_out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic job: 100 - 50 + 7 + 1000 = 1057.
    sb.push_back('{acc: 34'd1057, ovf: 1'b0});
    do_start(8'd4);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_prod_ready", 64'(prod_ready), 64'd1);
    send(32'd100);
    send(-32'sd50);
    send(32'd7);
    send(32'd1000);
    chk("basic_valid_after_last", 64'(acc_valid), 64'd1);
    chk("basic_ready_low_in_hold", 64'(prod_ready), 64'd0);
    chk("basic_acc_in_hold", 64'(acc_out), 64'd1057);
    take_result();
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_valid_after", 64'(acc_valid), 64'd0);

    // Zero-length job.
    sb.push_back('{acc: 34'd0, ovf: 1'b0});
    do_start(8'd0);
    chk("zero_valid", 64'(acc_valid), 64'd1);
    chk("zero_prod_ready", 64'(prod_ready), 64'd0);
    chk("zero_acc", 64'(acc_out), 64'd0);
    take_result();

    // Gapped input with backpressure and ignored start pulses in HOLD.
    sb.push_back('{acc: NEG3, ovf: 1'b0});
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      send(32'hFFFF_FFFF);
      if (i < 2) begin
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      len   = 8'd5;
      chk("gap_hold_valid", 64'(acc_valid), 64'd1);
      chk("gap_hold_acc", 64'(acc_out), 64'(NEG3));
      @(posedge clk); #1;
    end
    start = 1'b0;
    take_result();
    chk("gap_busy_after", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("gap_start_not_queued", 64'(busy), 64'd0);

    // Overflow: five products of 0x7FFFFFFF exceed the 34-bit signed range.
    sb.push_back('{acc: OVF_EXP, ovf: 1'b1});
    do_start(8'd5);
    for (int i = 0; i < 5; i++) send(32'h7FFF_FFFF);
    chk("ovf_flag_in_hold", 64'(overflow), 64'd1);
    take_result();

    // Reset in the middle of a job.
    do_start(8'd8);
    for (int i = 0; i < 3; i++) send(32'd1000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_acc_valid", 64'(acc_valid), 64'd0);
    chk("midrst_prod_ready", 64'(prod_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_acc_out", 64'(acc_out), 64'd0);
    rst = 1'b0;
    sb.push_back('{acc: 34'd42, ovf: 1'b0});
    do_start(8'd1);
    send(32'd42);
    take_result();

    // Back-to-back: overflowing job, then start in the cycle after handshake.
    sb.push_back('{acc: OVF_EXP, ovf: 1'b1});
    do_start(8'd5);
    for (int i = 0; i < 5; i++) send(32'h7FFF_FFFF);
    take_result();
    sb.push_back('{acc: NEG2, ovf: 1'b0});
    do_start(8'd2);
    chk("b2b_start_accepted", 64'(busy), 64'd1);
    chk("b2b_ovf_cleared", 64'(overflow), 64'd0);
    chk("b2b_acc_cleared", 64'(acc_out), 64'd0);
    send(32'd5);
    send(-32'sd7);
    take_result();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
